// File: rtl/ota_duty_capture.sv
// ota_duty_capture: synchronizes the asynchronous comparator pin, optionally
// glitch-filters it, and measures duty (high samples) and edge count over a
// programmable window of window+1 samples, ending with a one-cycle done pulse.
// Optional feature: define OTA_CAPTURE_GLITCH_FILTER_EN to insert a registered
// majority-of-3 filter after the synchronizer (one extra cycle of latency).
module ota_duty_capture #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmp_in,
    input  logic             start,
    input  logic [CNT_W-1:0] window,
    output logic             busy,
    output logic             done,
    output logic [CNT_W:0]   duty,
    output logic [CNT_W-1:0] edges,
    output logic             level
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;
    logic                   s;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   duty_acc_q, duty_acc_d;
    logic [CNT_W-1:0] edge_acc_q, edge_acc_d;
    logic             prev_q, prev_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W:0]   duty_q, duty_d;
    logic [CNT_W-1:0] edges_q, edges_d;

    // Synchronizer shift: the pin enters at bit 0 and leaves at the top bit.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], cmp_in};
    end

    // Synchronizer flops, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef OTA_CAPTURE_GLITCH_FILTER_EN
    // The vote uses three consecutive synchronizer outputs: the one about to
    // appear (penultimate stage), the current one, and the previous one. Using
    // the penultimate stage keeps the added latency to a single cycle.
    logic sync_next;
    logic hist_q, hist_d;
    logic filt_q, filt_d;

    assign sync_next = sync_q[SYNC_STAGES-2];

    // Majority vote over three consecutive synchronized samples.
    always_comb begin
        hist_d = sync_out;
        filt_d = (sync_next & sync_out) | (sync_next & hist_q) | (sync_out & hist_q);
    end

    // Filter history and output, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            filt_q <= filt_d;
        end
    end

    assign s = filt_q;
`else
    assign s = sync_out;
`endif

    assign level = s;

    // Measurement FSM, accumulators and result registers (next-state logic).
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
        duty_acc_d = duty_acc_q;
        edge_acc_d = edge_acc_q;
        prev_d     = prev_q;
        duty_d     = duty_q;
        edges_d    = edges_q;
        busy_d     = (state_q != ST_IDLE);
        done_d     = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    win_d      = window;
                    cnt_d      = '0;
                    duty_acc_d = '0;
                    edge_acc_d = '0;
                    state_d    = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                duty_acc_d = duty_acc_q + {{CNT_W{1'b0}}, s};
                // The first sample has no predecessor, so it never counts an edge.
                if ((cnt_q != '0) && (s != prev_q)) begin
                    edge_acc_d = edge_acc_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
                prev_d = s;
                if (cnt_q == win_q) state_d = ST_DONE;
                else                cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            ST_DONE: begin
                duty_d  = duty_acc_q;
                edges_d = edge_acc_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset discards any partial measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            cnt_q      <= '0;
            duty_acc_q <= '0;
            edge_acc_q <= '0;
            prev_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            duty_q     <= '0;
            edges_q    <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
            duty_acc_q <= duty_acc_d;
            edge_acc_q <= edge_acc_d;
            prev_q     <= prev_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            duty_q     <= duty_d;
            edges_q    <= edges_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign duty  = duty_q;
    assign edges = edges_q;

endmodule

// File: doc/ota_duty_capture.md
# ota_duty_capture

Digital read-back end for the gate-level OTA/comparator: takes its asynchronous output pin, synchronizes and optionally filters it, and measures it over a programmable sampling window. It reports the number of high samples (duty) and the number of level transitions (edges) with a one-cycle done strobe. It lets the digital side characterize the comparator without an external logic analyzer.

## Interface
- CNT_W, 8: width of the window register and edge counter; duty is CNT_W+1 bits.
- SYNC_STAGES, 2: flip-flop stages in the input synchronizer; minimum 2.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmp_in  in  1  asynchronous comparator output taken from the analog pin.
- start  in  1  single-cycle request to begin a measurement.
- window  in  CNT_W  sample count minus one; a measurement is window+1 samples (1..2^CNT_W). Captured on the accepted start.
- busy  out  1  high while a measurement is in progress, including the done cycle.
- done  out  1  one-cycle pulse; results are valid from this cycle on.
- duty  out  CNT_W+1  count of high samples in the last window.
- edges  out  CNT_W  count of transitions between consecutive samples in the last window.
- level  out  1  current synchronized (and filtered, if built in) comparator level.

## Operation
- Synchronizer: SYNC_STAGES flops clocked by clk. All of them reset to 0.
- The sample stream s is the synchronizer output, or the filter output if the filter is built in.
- level = s at all times.
- FSM states: IDLE, SAMPLE, DONE. Reset enters IDLE.
- IDLE: start=1 does the following:
  - latches window into win_q;
  - clears the duty and edge accumulators and the sample counter;
  - moves to SAMPLE.
- SAMPLE: each cycle takes one sample of s.
  - The duty accumulator increments when s=1.
  - From the second sample onward, the edge accumulator increments when s differs from the previous sample.
  - After sample number win_q+1, the FSM moves to DONE.
- DONE: lasts one cycle.
  - The accumulators are copied into the duty/edges output registers and done is asserted.
  - The FSM returns to IDLE.
- Output registers hold their values until the next DONE or reset. They do not change during a new measurement.
- start is ignored outside IDLE. It is not queued.
- window is ignored except on the accepted start.
- Width rules:
  - duty ≤ win_q+1 ≤ 2^CNT_W, so it fits in CNT_W+1 bits.
  - edges ≤ win_q, so it fits in CNT_W bits.
  - Neither counter saturates or wraps.
- Reset mid-measurement (rst=1 at any edge):
  - FSM goes to IDLE.
  - busy, done, duty, edges, level, the accumulators and the synchronizer all go to 0.
  - The partial measurement is discarded.

## Timing
- Reset values: busy=0, done=0, duty=0, edges=0, level=0.
- Input latency: a change on cmp_in appears on level after SYNC_STAGES edges. Add 1 edge with the filter.
- Measurement latency: start sampled at edge T.
  - busy is high from T+1.
  - Samples are taken at edges T+1 .. T+win_q+1.
  - done is high in the cycle after edge T+win_q+2; busy falls at edge T+win_q+3.
- Back-to-back: a start in the first cycle after done clears is accepted. Minimum spacing between start pulses is win_q+3 cycles.
- start and rst high together: rst wins.

## Configuration
- OTA_CAPTURE_GLITCH_FILTER_EN defined:
  - A registered majority-of-3 filter over the last three synchronizer outputs drives s.
  - This adds one cycle of latency and rejects isolated single-cycle pulses.
  - The filter history resets to 0.
- Not defined: s is the synchronizer output directly, with no extra latency. Every synchronized pulse is counted.

## Test plan
- cmp_in held 1, window=9, start at T -> done at T+11 cycle, duty=10, edges=0, busy low after.
- cmp_in toggled every clk (after sync), window=255 -> duty=128, edges=255.
- cmp_in held 0, window=0 -> duty=0, edges=0, done 2 cycles after start; outputs hold until next done.
- Second start pulsed during SAMPLE with a different window -> ignored; the result reflects the first window and only one done occurs.
- rst asserted at the 5th sample of a window=20 run -> all outputs 0 next cycle, no done; a new start then measures normally.
- Isolated 1-cycle high pulse on cmp_in, window=15 -> duty=0 and edges=0 with OTA_CAPTURE_GLITCH_FILTER_EN; duty=1 and edges=2 (pulse mid-window) without it.
